khu_pad_input_conditioner: RTL and testbench

- Sits between the pad-ring input buffers and khu_sensor_top. All pad-derived inputs pass through it before reaching core logic.
- Generates the core reset: asynchronous assert, synchronous stretched deassert.
- Synchronises every asynchronous pad input to CLK. Optionally glitch-filters the MPR121 I2C lines.
- Provides edge and bus-event strobes: ADS1292 DRDY falling edge, I2C START/STOP, I2C bus-busy.

---
 rtl/khu_pad_input_conditioner.sv | 158 +++++++++++++++
 tb/tb_khu_pad_input_conditioner.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/khu_pad_input_conditioner.sv
// Pad-side input conditioning: core reset generation, input synchronisers and I2C bus-event strobes.
// Optional I2C glitch filter on SCL/SDA is enabled by defining KHU_I2C_GLITCH_FILT_EN.
module khu_pad_input_conditioner #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 3,
   parameter int unsigned RST_STRETCH = 4
) (
   input  logic CLK,
   input  logic RSTN,
   output logic RSTN_SYNC_O,
   input  logic UART_RXD_I,
   input  logic ADS1292_MISO_I,
   input  logic ADS1292_DRDY_I,
   input  logic MPR121_SCL_IN_I,
   input  logic MPR121_SDA_IN_I,
   output logic UART_RXD_O,
   output logic ADS1292_MISO_O,
   output logic ADS1292_DRDY_O,
   output logic ADS1292_DRDY_FALL_O,
   output logic MPR121_SCL_O,
   output logic MPR121_SDA_O,
   output logic I2C_START_O,
   output logic I2C_STOP_O,
   output logic I2C_BUSY_O
);

   localparam int unsigned SL    = SYNC_STAGES - 1;
   localparam int unsigned CNT_W = 4;

   generate
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
         $error("SYNC_STAGES must be in 2..4");
      end
      if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_bad_filt
         $error("FILT_LEN must be in 2..15");
      end
      if (RST_STRETCH < 2 || RST_STRETCH > 16) begin : g_bad_stretch
         $error("RST_STRETCH must be in 2..16");
      end
   endgenerate

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } busy_state_e;

   logic [RST_STRETCH-1:0] rst_q;
   logic [SL:0]            uart_q;
   logic [SL:0]            miso_q;
   logic [SL:0]            drdy_q;
   logic [SL:0]            scl_s_q;
   logic [SL:0]            sda_s_q;
   logic                   drdy_fall_q;
   logic                   start_q;
   logic                   stop_q;
   busy_state_e            state_q;

   // Bit 1 = SCL, bit 0 = SDA; line_q is the conditioned value now, line_d its value after the next edge.
   logic [1:0] sync_cur;
   logic [1:0] line_q;
   logic [1:0] line_d;
   logic       start_c;
   logic       stop_c;

   // Reset stretcher and synchroniser chains; DRDY fall is registered from the value about to reach the output.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rst_q       <= '0;
         uart_q      <= '1;
         miso_q      <= '0;
         drdy_q      <= '1;
         scl_s_q     <= '1;
         sda_s_q     <= '1;
         drdy_fall_q <= 1'b0;
      end else begin
         rst_q       <= {rst_q[RST_STRETCH-2:0], 1'b1};
         uart_q      <= {uart_q[SL-1:0], UART_RXD_I};
         miso_q      <= {miso_q[SL-1:0], ADS1292_MISO_I};
         drdy_q      <= {drdy_q[SL-1:0], ADS1292_DRDY_I};
         scl_s_q     <= {scl_s_q[SL-1:0], MPR121_SCL_IN_I};
         sda_s_q     <= {sda_s_q[SL-1:0], MPR121_SDA_IN_I};
         drdy_fall_q <= drdy_q[SL] & ~drdy_q[SL-1];
      end
   end

   assign sync_cur = {scl_s_q[SL], sda_s_q[SL]};

`ifdef KHU_I2C_GLITCH_FILT_EN
   logic [1:0]            filt_q;
   logic [1:0]            filt_d;
   logic [1:0][CNT_W-1:0] cnt_q;
   logic [1:0][CNT_W-1:0] cnt_d;

   // A line follows its synchroniser only after FILT_LEN consecutive disagreeing cycles.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync_cur[i] != filt_q[i]) begin
            if (cnt_q[i] == CNT_W'(FILT_LEN - 1)) begin
               filt_d[i] = sync_cur[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         filt_q <= '1;
         cnt_q  <= '0;
      end else begin
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign line_q = filt_q;
   assign line_d = filt_d;
`else
   assign line_q = sync_cur;
   assign line_d = {scl_s_q[SL-1], sda_s_q[SL-1]};
`endif

   // Events are decoded on the transition being registered so strobes and BUSY appear with the new line values.
   always_comb begin
      start_c = line_q[1] & line_d[1] &  line_q[0] & ~line_d[0];
      stop_c  = line_q[1] & line_d[1] & ~line_q[0] &  line_d[0];
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= ST_IDLE;
         start_q <= 1'b0;
         stop_q  <= 1'b0;
      end else begin
         start_q <= start_c;
         stop_q  <= stop_c;
         case (state_q)
            ST_IDLE: if (start_c) state_q <= ST_BUSY;
            ST_BUSY: if (stop_c)  state_q <= ST_IDLE;
         endcase
      end
   end

   assign RSTN_SYNC_O         = rst_q[RST_STRETCH-1];
   assign UART_RXD_O          = uart_q[SL];
   assign ADS1292_MISO_O      = miso_q[SL];
   assign ADS1292_DRDY_O      = drdy_q[SL];
   assign ADS1292_DRDY_FALL_O = drdy_fall_q;
   assign MPR121_SCL_O        = line_q[1];
   assign MPR121_SDA_O        = line_q[0];
   assign I2C_START_O         = start_q;
   assign I2C_STOP_O          = stop_q;
   assign I2C_BUSY_O          = (state_q == ST_BUSY);

endmodule

// File: tb/tb_khu_pad_input_conditioner.sv
// Bench for khu_pad_input_conditioner: edge-indexed pad history model checked every cycle,
// plus directed latency/strobe checks. Honours KHU_I2C_GLITCH_FILT_EN like the design.
module tb_khu_pad_input_conditioner;

   localparam int SYNC    = 2;
   localparam int FILT    = 3;
   localparam int STRETCH = 4;
   localparam int MAXE    = 4096;
`ifdef KHU_I2C_GLITCH_FILT_EN
   localparam bit FILT_ON = 1'b1;
`else
   localparam bit FILT_ON = 1'b0;
`endif
   localparam int I2C_LAT = FILT_ON ? SYNC + FILT : SYNC;

   logic clk    = 1'b0;
   logic rstn   = 1'b0;
   logic uart_i = 1'b1;
   logic miso_i = 1'b0;
   logic drdy_i = 1'b1;
   logic scl_i  = 1'b1;
   logic sda_i  = 1'b1;
   logic rstn_sync_o, uart_o, miso_o, drdy_o, drdy_fall_o;
   logic scl_o, sda_o, start_o, stop_o, busy_o;

   khu_pad_input_conditioner #(
      .SYNC_STAGES(SYNC), .FILT_LEN(FILT), .RST_STRETCH(STRETCH)
   ) dut (
      .CLK(clk), .RSTN(rstn), .RSTN_SYNC_O(rstn_sync_o),
      .UART_RXD_I(uart_i), .ADS1292_MISO_I(miso_i), .ADS1292_DRDY_I(drdy_i),
      .MPR121_SCL_IN_I(scl_i), .MPR121_SDA_IN_I(sda_i),
      .UART_RXD_O(uart_o), .ADS1292_MISO_O(miso_o), .ADS1292_DRDY_O(drdy_o),
      .ADS1292_DRDY_FALL_O(drdy_fall_o), .MPR121_SCL_O(scl_o), .MPR121_SDA_O(sda_o),
      .I2C_START_O(start_o), .I2C_STOP_O(stop_o), .I2C_BUSY_O(busy_o)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   task automatic cmp(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model: outputs as functions of pad samples indexed by edges since reset release
   int   ecount = 0;
   logic h_pad [5][MAXE];   // 0 uart, 1 miso, 2 drdy, 3 scl, 4 sda
   logic m_line[2][MAXE];   // 0 scl, 1 sda (conditioned)
   logic m_start[MAXE];
   logic m_stop [MAXE];
   logic m_busy [MAXE];
   int   last_chg[2];

   function automatic logic rst_val(input int sig);
      return (sig == 1) ? 1'b0 : 1'b1;
   endfunction

   // Value an n-edge-old synchroniser shows: pad sampled SYNC-1 edges earlier, else its reset value.
   function automatic logic sync_at(input int sig, input int n);
      if (n < SYNC) return rst_val(sig);
      return h_pad[sig][n - SYNC + 1];
   endfunction

   task automatic model_reset();
      ecount     = 0;
      m_line[0][0] = 1'b1;
      m_line[1][0] = 1'b1;
      m_start[0] = 1'b0;
      m_stop[0]  = 1'b0;
      m_busy[0]  = 1'b0;
      last_chg[0] = 0;
      last_chg[1] = 0;
   endtask

   task automatic model_step(input int n);
      logic prev, nv;
      bit   flip;
      for (int l = 0; l < 2; l++) begin
         prev = m_line[l][n-1];
         nv   = prev;
         if (!FILT_ON) begin
            nv = sync_at(l + 3, n);
         end else if (n - FILT >= last_chg[l]) begin
            flip = 1'b1;
            for (int k = n - FILT; k < n; k++)
               if (sync_at(l + 3, k) == prev) flip = 1'b0;
            if (flip) begin
               nv = ~prev;
               last_chg[l] = n;
            end
         end
         m_line[l][n] = nv;
      end
      m_start[n] = m_line[0][n-1] && m_line[0][n] &&  m_line[1][n-1] && !m_line[1][n];
      m_stop[n]  = m_line[0][n-1] && m_line[0][n] && !m_line[1][n-1] &&  m_line[1][n];
      m_busy[n]  = m_start[n] ? 1'b1 : (m_stop[n] ? 1'b0 : m_busy[n-1]);
   endtask

   initial model_reset();

   initial forever begin
      @(negedge rstn);
      model_reset();
   end

   initial forever begin
      @(posedge clk);
      if (rstn && ecount < MAXE - 1) begin
         ecount++;
         h_pad[0][ecount] = uart_i;
         h_pad[1][ecount] = miso_i;
         h_pad[2][ecount] = drdy_i;
         h_pad[3][ecount] = scl_i;
         h_pad[4][ecount] = sda_i;
         model_step(ecount);
      end
   end

   // Per-cycle comparison against the model, 3 time units after each rising edge.
   initial forever begin
      int n;
      @(posedge clk);
      #3;
      n = ecount;
      cmp("rstn_sync", rstn_sync_o, logic'(rstn && n >= STRETCH));
      cmp("uart", uart_o, sync_at(0, n));
      cmp("miso", miso_o, sync_at(1, n));
      cmp("drdy", drdy_o, sync_at(2, n));
      cmp("drdy_fall", drdy_fall_o, logic'(n >= 1 && sync_at(2, n - 1) && !sync_at(2, n)));
      cmp("scl", scl_o, m_line[0][n]);
      cmp("sda", sda_o, m_line[1][n]);
      cmp("start", start_o, m_start[n]);
      cmp("stop", stop_o, m_stop[n]);
      cmp("busy", busy_o, m_busy[n]);
   end

   // ---------------- directed observation window
   int w_first_rstn1, w_first_uart0, w_first_miso1, w_first_drdy0, w_first_fall;
   int w_first_start, w_first_stop, w_n_fall;
   int tot_start, tot_stop, any_idle, any_busy, any_sda_low;
   int start_wo_busy = 0;

   task automatic clr_tally();
      tot_start = 0; tot_stop = 0; any_idle = 0; any_busy = 0; any_sda_low = 0;
   endtask

   // Samples n cycles (index 1 = first edge after the call) and returns at the following falling edge.
   task automatic watch(input int n);
      w_first_rstn1 = -1; w_first_uart0 = -1; w_first_miso1 = -1; w_first_drdy0 = -1;
      w_first_fall = -1; w_first_start = -1; w_first_stop = -1; w_n_fall = 0;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk);
         #3;
         if (rstn_sync_o && w_first_rstn1 < 0) w_first_rstn1 = i;
         if (!uart_o && w_first_uart0 < 0) w_first_uart0 = i;
         if (miso_o && w_first_miso1 < 0) w_first_miso1 = i;
         if (!drdy_o && w_first_drdy0 < 0) w_first_drdy0 = i;
         if (drdy_fall_o) begin
            w_n_fall++;
            if (w_first_fall < 0) w_first_fall = i;
         end
         if (start_o) begin
            tot_start++;
            if (w_first_start < 0) w_first_start = i;
            if (!busy_o) start_wo_busy++;
         end
         if (stop_o) begin
            tot_stop++;
            if (w_first_stop < 0) w_first_stop = i;
         end
         if (busy_o) any_busy = 1; else any_idle = 1;
         if (!sda_o) any_sda_low = 1;
      end
      @(negedge clk);
   endtask

   task automatic phase(input logic scl_v, input logic sda_v, input int n);
      scl_i = scl_v;
      sda_i = sda_v;
      watch(n);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset held, then released: output rises on the 4th edge
      repeat (10) @(negedge clk);
      cmp("reset_rstn_sync", rstn_sync_o, 1'b0);
      cmp("reset_uart", uart_o, 1'b1);
      cmp("reset_miso", miso_o, 1'b0);
      cmp("reset_drdy", drdy_o, 1'b1);
      cmp("reset_scl", scl_o, 1'b1);
      cmp("reset_sda", sda_o, 1'b1);
      cmp("reset_busy", busy_o, 1'b0);
      rstn = 1'b1;
      watch(8);
      cmp_int("release_latency", w_first_rstn1, STRETCH);

      // Synchroniser latency
      uart_i = 1'b0;
      watch(4);
      cmp_int("uart_latency", w_first_uart0, SYNC);
      miso_i = 1'b1;
      watch(4);
      cmp_int("miso_latency", w_first_miso1, SYNC);

      // Asynchronous assertion with no clock edge
      rstn = 1'b0;
      #1;
      cmp("async_rstn_sync", rstn_sync_o, 1'b0);
      cmp("async_uart", uart_o, 1'b1);
      cmp("async_miso", miso_o, 1'b0);
      uart_i = 1'b1;
      miso_i = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      watch(2);
      cmp_int("stretch_partial", w_first_rstn1, -1);
      rstn = 1'b0;
      #1;
      cmp("restart_rstn_sync", rstn_sync_o, 1'b0);
      #1;
      rstn = 1'b1;
      watch(8);
      cmp_int("restart_latency", w_first_rstn1, STRETCH);

      // DRDY falling-edge strobe
      drdy_i = 1'b0;
      watch(20);
      cmp_int("drdy_fall_count", w_n_fall, 1);
      cmp_int("drdy_fall_cycle", w_first_fall, SYNC);
      cmp_int("drdy_low_cycle", w_first_drdy0, SYNC);
      drdy_i = 1'b1;
      watch(10);
      cmp_int("drdy_rise_no_strobe", w_n_fall, 0);

      // I2C transaction: START, 9 clocks, STOP
      clr_tally();
      phase(1'b1, 1'b0, 15);
      cmp_int("start_latency", w_first_start, I2C_LAT);
      cmp_int("start_count", tot_start, 1);
      cmp("start_busy", busy_o, 1'b1);
      clr_tally();
      for (int p = 0; p < 9; p++) begin
         phase(1'b0, sda_i, 10);
         phase(1'b0, logic'(p % 2), 10);
         phase(1'b1, logic'(p % 2), 20);
      end
      cmp_int("clock_strobes", tot_start + tot_stop, 0);
      cmp_int("clock_busy_held", any_idle, 0);
      clr_tally();
      phase(1'b1, 1'b1, 15);
      cmp_int("stop_latency", w_first_stop, I2C_LAT);
      cmp_int("stop_count", tot_stop, 1);
      cmp("stop_busy", busy_o, 1'b0);

      // Repeated START keeps BUSY
      phase(1'b1, 1'b0, 12);
      clr_tally();
      phase(1'b0, 1'b0, 10);
      phase(1'b0, 1'b1, 10);
      phase(1'b1, 1'b1, 10);
      phase(1'b1, 1'b0, 12);
      cmp_int("rstart_count", tot_start, 1);
      cmp_int("rstart_stops", tot_stop, 0);
      cmp_int("rstart_busy_held", any_idle, 0);
      phase(1'b0, 1'b0, 10);
      phase(1'b1, 1'b0, 10);
      phase(1'b1, 1'b1, 12);
      cmp("rstart_stop_busy", busy_o, 1'b0);

      // STOP while idle
      clr_tally();
      phase(1'b0, 1'b1, 10);
      phase(1'b0, 1'b0, 10);
      phase(1'b1, 1'b0, 10);
      phase(1'b1, 1'b1, 12);
      cmp_int("idle_stop_count", tot_stop, 1);
      cmp_int("idle_stop_starts", tot_start, 0);
      cmp_int("idle_stop_busy", any_busy, 0);

      // SCL and SDA changing together
      clr_tally();
      phase(1'b0, 1'b1, 10);
      phase(1'b1, 1'b0, 10);
      phase(1'b0, 1'b1, 10);
      phase(1'b1, 1'b1, 10);
      cmp_int("simul_strobes", tot_start + tot_stop, 0);

      // Two-cycle SDA glitch with SCL high
      clr_tally();
      phase(1'b1, 1'b0, 2);
      phase(1'b1, 1'b1, 15);
      cmp_int("glitch_starts", tot_start, FILT_ON ? 0 : 1);
      cmp_int("glitch_stops", tot_stop, FILT_ON ? 0 : 1);
      cmp_int("glitch_sda_low", any_sda_low, FILT_ON ? 0 : 1);
      cmp_int("glitch_busy", any_busy, FILT_ON ? 0 : 1);

      // Reset while a START strobe is high
      clr_tally();
      phase(1'b1, 1'b0, I2C_LAT);
      cmp_int("midop_start_latency", w_first_start, I2C_LAT);
      cmp("midop_start_before", start_o, 1'b1);
      cmp("midop_busy_before", busy_o, 1'b1);
      rstn = 1'b0;
      #1;
      cmp("midop_start", start_o, 1'b0);
      cmp("midop_busy", busy_o, 1'b0);
      cmp("midop_sda", sda_o, 1'b1);
      cmp("midop_rstn_sync", rstn_sync_o, 1'b0);
      sda_i = 1'b1;
      @(negedge clk);
      rstn = 1'b1;
      clr_tally();
      watch(10);
      cmp_int("midop_release_latency", w_first_rstn1, STRETCH);
      cmp_int("midop_no_strobes", tot_start + tot_stop, 0);
      cmp_int("start_without_busy", start_wo_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
